clock_gen: RTL and testbench
============================

Name: clock_gen

Overview:
- Central clock generator for the FPGA floppy system. Derives all system timing from the single board oscillator `fpga_clk` (50 MHz, 20 ns period).
- Outputs:
  - `clk`: a square-wave system/FDC clock.
  - `phi_0`, `phi_2`: the 1 MHz 6502-style bus phase clocks.
  - `clk_sel_fdc`: a bus-slot select that grants the FDC the bus during the CPU-idle phase.
- All outputs are registered and glitch-free.

Parameters:
- PHI_DIV, 50, fpga_clk cycles per phi period. Must be even and ≥ 8. Default gives 1 MHz.
- PHI2_DELAY, 2, fpga_clk cycles by which the phi_2 rising edge lags phi_0 rising. Range 0 .. PHI_DIV/2-2.
- CLK_DIV, 4, fpga_clk cycles per clk period. Must be even and ≥ 2. Default gives 12.5 MHz.

Ports:
- fpga_clk  input  1  board oscillator; all logic on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- clk  output  1  system clock, fpga_clk/CLK_DIV, 50 % duty.
- phi_0  output  1  CPU phase-0 clock, fpga_clk/PHI_DIV, 50 % duty.
- phi_2  output  1  CPU phase-2 clock, derived from phi_0.
- clk_sel_fdc  output  1  high while the FDC owns the bus slot.

Behaviour:
- Interface: one clock (`fpga_clk`). Reset (`reset`) is asynchronous and active-high.
- While reset=1:
  - Counters pcnt and ccnt are held at 0.
  - clk, phi_0, phi_2 and clk_sel_fdc are held at 0.
  - Reset asserted mid-period forces all outputs low immediately, without waiting for a clock edge.
- pcnt counts 0..PHI_DIV-1 and increments every fpga_clk edge. It wraps PHI_DIV-1 → 0.
- ccnt counts 0..CLK_DIV-1 and increments every edge. It wraps CLK_DIV-1 → 0. ccnt is independent of pcnt.
- Each output is registered from the current counter value (pre-increment), evaluated at the same edge.
- phi_0 ← (pcnt < PHI_DIV/2). The first edge after reset release drives phi_0 to 1.
  - phi_0 is high for exactly PHI_DIV/2 cycles, then low for PHI_DIV/2 cycles.
- clk ← (ccnt < CLK_DIV/2). The first edge after release drives clk to 1.
  - clk is high CLK_DIV/2 cycles and low CLK_DIV/2 cycles.
- phi_2: see Optional Feature.
- clk_sel_fdc ← (pcnt ≥ PHI_DIV/2+1) AND (pcnt ≤ PHI_DIV-2).
  - Rises 1 cycle after phi_0 falls.
  - Falls 1 cycle before phi_0 rises, giving a one-cycle guard on each side.
  - Default timing: high 23 cycles per period.
- clk_sel_fdc is never high while phi_0 or phi_2 is high.
- With the default phase length (PHI_DIV/2 = 25), all phase clocks are in a known state from the first edge after release. No output ever toggles twice within one fpga_clk cycle.
- Parameter legality is checked at elaboration. An illegal value (odd divisor, or PHI2_DELAY out of range) stops elaboration with an error message.

Optional Feature:
- Macro: CLOCK_GEN_NONOVERLAP_EN.
- Defined:
  - phi_2 ← (pcnt ≥ PHI2_DELAY) AND (pcnt < PHI_DIV/2).
  - phi_2 rises PHI2_DELAY cycles after phi_0 rises and falls on the same edge as phi_0.
  - Default timing: high 23 cycles.
- Not defined:
  - phi_2 ← same expression as phi_0, so it is cycle-identical to phi_0.
  - PHI2_DELAY is ignored and not range-checked.

Test Plan:
1. Reset hold: reset=1 for 10 cycles with fpga_clk toggling → all four outputs 0 throughout.
   - Assert reset mid-high-phase of phi_0 → phi_0 goes to 0 without waiting for a clock edge.
2. phi_0 timing, defaults: release reset, measure 5 periods.
   - phi_0 rises on the 1st edge after release.
   - 25 cycles high / 25 cycles low; period 1000 ns (1 MHz).
3. clk timing, CLK_DIV=4: clk pattern 1,1,0,0 repeating from the 1st edge; period 80 ns.
   - Repeat with CLK_DIV=2: 1,0 repeating.
4. phi_2 with CLOCK_GEN_NONOVERLAP_EN and PHI2_DELAY=2:
   - phi_2 rises 2 edges after phi_0 rises and falls on the phi_0 falling edge; high 23 cycles.
   - Without the macro: phi_2 equals phi_0 on every cycle.
5. clk_sel_fdc: defaults.
   - Rises 1 cycle after phi_0 falls and is high 23 cycles.
   - Falls 1 cycle before phi_0 rises.
   - Assert (phi_0 | phi_2) & clk_sel_fdc == 0 on every cycle over 20 periods.
6. Non-default PHI_DIV=8: phi_0 shows 4 high / 4 low; clk_sel_fdc high 2 cycles per period.
   - Counters wrap cleanly across 100 periods with no drift against a reference model.

Source files
------------

// File: rtl/clock_gen.sv
`timescale 1ns/1ps
// clock_gen: derives clk, phi_0/phi_2 and the FDC bus-slot select from fpga_clk.
// Define CLOCK_GEN_NONOVERLAP_EN to delay phi_2 by PHI2_DELAY cycles inside phi_0.
module clock_gen #(
    parameter int PHI_DIV    = 50,
    parameter int PHI2_DELAY = 2,
    parameter int CLK_DIV    = 4
) (
    input  logic fpga_clk,
    input  logic reset,
    output logic clk,
    output logic phi_0,
    output logic phi_2,
    output logic clk_sel_fdc
);
    localparam int PW = $clog2(PHI_DIV);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PHI_LAST  = PW'(PHI_DIV - 1);
    localparam logic [PW-1:0] PHI_HALF  = PW'(PHI_DIV / 2);
    localparam logic [PW-1:0] SEL_FIRST = PW'(PHI_DIV / 2 + 1);
    localparam logic [PW-1:0] SEL_LAST  = PW'(PHI_DIV - 2);
    localparam logic [CW-1:0] CLK_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CLK_HALF  = CW'(CLK_DIV / 2);

    if (((PHI_DIV % 2) != 0) || (PHI_DIV < 8)) begin : g_bad_phi_div
        $error("clock_gen: PHI_DIV must be even and >= 8");
    end
    if (((CLK_DIV % 2) != 0) || (CLK_DIV < 2)) begin : g_bad_clk_div
        $error("clock_gen: CLK_DIV must be even and >= 2");
    end
`ifdef CLOCK_GEN_NONOVERLAP_EN
    if ((PHI2_DELAY < 0) || (PHI2_DELAY > PHI_DIV / 2 - 2)) begin : g_bad_phi2_delay
        $error("clock_gen: PHI2_DELAY must be in 0 .. PHI_DIV/2-2");
    end
    localparam logic [PW-1:0] PHI2_START = PW'(PHI2_DELAY);
`endif

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [CW-1:0] ccnt_q, ccnt_d;
    logic          clk_q, clk_d;
    logic          phi_0_q, phi_0_d;
    logic          phi_2_q, phi_2_d;
    logic          sel_q, sel_d;

    // Outputs decode the pre-increment counter, so each lands exactly one edge later.
    always_comb begin
        pcnt_d  = (pcnt_q == PHI_LAST) ? '0 : pcnt_q + 1'b1;
        ccnt_d  = (ccnt_q == CLK_LAST) ? '0 : ccnt_q + 1'b1;
        clk_d   = (ccnt_q < CLK_HALF);
        phi_0_d = (pcnt_q < PHI_HALF);
`ifdef CLOCK_GEN_NONOVERLAP_EN
        phi_2_d = (pcnt_q >= PHI2_START) && (pcnt_q < PHI_HALF);
`else
        phi_2_d = (pcnt_q < PHI_HALF);
`endif
        sel_d   = (pcnt_q >= SEL_FIRST) && (pcnt_q <= SEL_LAST);
    end

    // NOTE: async reset in the sensitivity list clears outputs without a clock edge;
    // all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge fpga_clk or posedge reset) begin
        if (reset) begin
            pcnt_q  <= '0;
            ccnt_q  <= '0;
            clk_q   <= 1'b0;
            phi_0_q <= 1'b0;
            phi_2_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            pcnt_q  <= pcnt_d;
            ccnt_q  <= ccnt_d;
            clk_q   <= clk_d;
            phi_0_q <= phi_0_d;
            phi_2_q <= phi_2_d;
            sel_q   <= sel_d;
        end
    end

    assign clk         = clk_q;
    assign phi_0       = phi_0_q;
    assign phi_2       = phi_2_q;
    assign clk_sel_fdc = sel_q;

endmodule

// File: tb/tb_clock_gen.sv
`timescale 1ns/1ps
// tb_clock_gen: directed table vectors plus cycle-by-cycle reference model for three
// clock_gen configurations (defaults, CLK_DIV=2, PHI_DIV=8).
module tb_clock_gen;

`ifdef CLOCK_GEN_NONOVERLAP_EN
    localparam bit NONOV = 1'b1;
`else
    localparam bit NONOV = 1'b0;
`endif

    typedef struct {
        int edge_n;
        bit clk;
        bit phi_0;
        bit phi2_nov;
        bit sel;
    } vec_t;

    typedef struct {
        logic prev;
        int   len;
        bit   started;
    } run_t;

    localparam int NV = 14;

    logic fpga_clk = 1'b0;
    logic reset;
    logic d_clk, d_phi0, d_phi2, d_sel;
    logic c2_clk, c2_phi0, c2_phi2, c2_sel;
    logic p8_clk, p8_phi0, p8_phi2, p8_sel;

    int n_vec = 0;
    int n_err = 0;

    always #10 fpga_clk = ~fpga_clk;

    clock_gen u_def (
        .fpga_clk(fpga_clk), .reset(reset), .clk(d_clk),
        .phi_0(d_phi0), .phi_2(d_phi2), .clk_sel_fdc(d_sel)
    );

    clock_gen #(.CLK_DIV(2)) u_c2 (
        .fpga_clk(fpga_clk), .reset(reset), .clk(c2_clk),
        .phi_0(c2_phi0), .phi_2(c2_phi2), .clk_sel_fdc(c2_sel)
    );

    clock_gen #(.PHI_DIV(8)) u_p8 (
        .fpga_clk(fpga_clk), .reset(reset), .clk(p8_clk),
        .phi_0(p8_phi0), .phi_2(p8_phi2), .clk_sel_fdc(p8_sel)
    );

    wire [3:0] d_vec  = {d_clk, d_phi0, d_phi2, d_sel};
    wire [3:0] c2_vec = {c2_clk, c2_phi0, c2_phi2, c2_sel};
    wire [3:0] p8_vec = {p8_clk, p8_phi0, p8_phi2, p8_sel};

    // Expected {clk, phi_0, phi_2, sel} after the n-th edge following reset release.
    function automatic logic [3:0] model(input int n, input int pdiv, input int cdiv);
        int   pc, cc;
        logic c, p0, p2, s;
        if (n < 1) return 4'b0000;
        pc = (n - 1) % pdiv;
        cc = (n - 1) % cdiv;
        c  = (cc < cdiv / 2);
        p0 = (pc < pdiv / 2);
        p2 = NONOV ? ((pc >= 2) && (pc < pdiv / 2)) : p0;
        s  = (pc >= pdiv / 2 + 1) && (pc <= pdiv - 2);
        return {c, p0, p2, s};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Checks each completed high/low run length; an expected length of 0 skips that level.
    task automatic track(input string name, input logic cur, inout run_t r,
                         input int hi, input int lo);
        if (!r.started) begin
            r.prev = cur; r.len = 1; r.started = 1'b1;
        end else if (cur == r.prev) begin
            r.len++;
        end else begin
            if (r.prev && hi > 0)  check_int({name, "_high_len"}, r.len, hi);
            if (!r.prev && lo > 0) check_int({name, "_low_len"}, r.len, lo);
            r.prev = cur;
            r.len  = 1;
        end
    endtask

    vec_t tbl [NV];
    run_t r_p0, r_p2, r_sel, r_clk, r_c2clk, r_p8p0, r_p8sel;

    initial begin
        int     ti;
        longint t_p0, t_clk;
        logic   prev_p0, prev_clk;
        logic [3:0] exp_v;
        int     hc;
        int     found;

        tbl[0]  = '{1,   1, 1, 0, 0};
        tbl[1]  = '{2,   1, 1, 0, 0};
        tbl[2]  = '{3,   0, 1, 1, 0};
        tbl[3]  = '{4,   0, 1, 1, 0};
        tbl[4]  = '{5,   1, 1, 1, 0};
        tbl[5]  = '{25,  1, 1, 1, 0};
        tbl[6]  = '{26,  1, 0, 0, 0};
        tbl[7]  = '{27,  0, 0, 0, 1};
        tbl[8]  = '{49,  1, 0, 0, 1};
        tbl[9]  = '{50,  1, 0, 0, 0};
        tbl[10] = '{51,  0, 1, 0, 0};
        tbl[11] = '{52,  0, 1, 0, 0};
        tbl[12] = '{53,  1, 1, 1, 0};
        tbl[13] = '{101, 1, 1, 0, 0};

        r_p0 = '{1'b0, 0, 1'b0}; r_p2 = r_p0; r_sel = r_p0; r_clk = r_p0;
        r_c2clk = r_p0; r_p8p0 = r_p0; r_p8sel = r_p0;

        reset = 1'b1;
        repeat (10) begin
            @(negedge fpga_clk);
            check("reset_hold_def", d_vec, 4'b0000);
            check("reset_hold_p8", p8_vec, 4'b0000);
        end

        reset    = 1'b0;
        ti       = 0;
        t_p0     = -1;
        t_clk    = -1;
        prev_p0  = 1'b0;
        prev_clk = 1'b0;

        for (int n = 1; n <= 1000; n++) begin
            @(negedge fpga_clk);
            check("def_model", d_vec, model(n, 50, 4));
            check("c2_model", c2_vec, model(n, 50, 2));
            check("p8_model", p8_vec, model(n, 8, 4));
            check("def_no_overlap", {3'b000, d_sel & (d_phi0 | d_phi2)}, 4'b0000);
            check("p8_no_overlap", {3'b000, p8_sel & (p8_phi0 | p8_phi2)}, 4'b0000);

            if (ti < NV && tbl[ti].edge_n == n) begin
                exp_v = {tbl[ti].clk, tbl[ti].phi_0,
                         NONOV ? tbl[ti].phi2_nov : tbl[ti].phi_0, tbl[ti].sel};
                check($sformatf("table_edge_%0d", n), d_vec, exp_v);
                ti++;
            end

            track("def_phi0", d_phi0, r_p0, 25, 25);
            track("def_phi2", d_phi2, r_p2, NONOV ? 23 : 25, NONOV ? 0 : 25);
            track("def_sel", d_sel, r_sel, 23, 0);
            track("def_clk", d_clk, r_clk, 2, 2);
            track("c2_clk", c2_clk, r_c2clk, 1, 1);
            track("p8_phi0", p8_phi0, r_p8p0, 4, 4);
            track("p8_sel", p8_sel, r_p8sel, 2, 0);

            if (d_phi0 && !prev_p0) begin
                if (t_p0 >= 0) check_int("phi0_period_ns", int'($time - t_p0), 1000);
                t_p0 = $time;
            end
            if (d_clk && !prev_clk) begin
                if (t_clk >= 0) check_int("clk_period_ns", int'($time - t_clk), 80);
                t_clk = $time;
            end
            prev_p0  = d_phi0;
            prev_clk = d_clk;
        end

        // Asynchronous reset in the middle of a phi_0 high phase.
        hc    = 0;
        found = 0;
        for (int k = 0; k < 120 && found == 0; k++) begin
            @(negedge fpga_clk);
            hc = d_phi0 ? hc + 1 : 0;
            if (hc == 10) found = 1;
        end
        check_int("mid_high_found", found, 1);
        #3 reset = 1'b1;
        #1;
        check("async_reset_phi0", {3'b000, d_phi0}, 4'b0000);
        check("async_reset_def", d_vec, 4'b0000);
        check("async_reset_c2", c2_vec, 4'b0000);
        check("async_reset_p8", p8_vec, 4'b0000);

        repeat (10) begin
            @(negedge fpga_clk);
            check("reset_hold2_def", d_vec, 4'b0000);
        end

        reset = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge fpga_clk);
            check("rerelease_def", d_vec, model(n, 50, 4));
            check("rerelease_c2", c2_vec, model(n, 50, 2));
            check("rerelease_p8", p8_vec, model(n, 8, 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
